cdc_xfer_arbiter: RTL and testbench

- Source-clock-domain scheduler that shares the single load/data CDC channel between NREQ requesters.
- Round-robin arbitration; one transfer in flight at a time.
- Launches each transfer as a one-cycle load pulse with held data, then waits for the destination acknowledgement.
- Acknowledgement arrives already synchronised into CLK; a timeout recovers from a lost acknowledgement.

---
 rtl/cdc_xfer_arbiter.sv | 101 ++++++++++
 tb/tb_cdc_xfer_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_xfer_arbiter.sv
// Round-robin scheduler sharing one load/data CDC channel between NREQ requesters.
// One transfer in flight; each ends on chan_ack or on a timeout, then waits GAP idle cycles.
module cdc_xfer_arbiter #(
  parameter int DATAWIDTH = 8,
  parameter int NREQ      = 4,
  parameter int TIMEOUT   = 63,
  parameter int GAP       = 2,
  parameter int IDW       = $clog2(NREQ)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DATAWIDTH-1:0] req_data,
  output logic [NREQ-1:0]           gnt,
  output logic [IDW-1:0]            gnt_id,
  output logic [DATAWIDTH-1:0]      chan_data,
  output logic                      chan_load,
  input  logic                      chan_ack,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam int GCW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GAP} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [WCW-1:0] wcnt;
  logic [GCW-1:0] gcnt;

  logic           sel_vld;
  logic [IDW-1:0] sel_idx;
  logic [IDW-1:0] ptr_nxt;

  // First set request at or above the pointer, wrapping modulo NREQ.
  always_comb begin
    int j;
    sel_vld = 1'b0;
    sel_idx = '0;
    j       = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!sel_vld && req[j]) begin
        sel_vld = 1'b1;
        sel_idx = IDW'(j);
      end
    end
  end

  assign ptr_nxt = (sel_idx == IDW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
  assign busy    = (state != S_IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      ptr         <= '0;
      wcnt        <= '0;
      gcnt        <= '0;
      gnt         <= '0;
      gnt_id      <= '0;
      chan_data   <= '0;
      chan_load   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      gnt         <= '0;
      chan_load   <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sel_vld) begin
            gnt       <= {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
            gnt_id    <= sel_idx;
            chan_data <= req_data[sel_idx*DATAWIDTH +: DATAWIDTH];
            chan_load <= 1'b1;
            ptr       <= ptr_nxt;
            wcnt      <= '0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // An ack arriving on the timeout cycle wins over the error.
          if (chan_ack || wcnt == WCW'(TIMEOUT - 1)) begin
            timeout_err <= !chan_ack;
            gcnt        <= '0;
            state       <= (GAP == 0) ? S_IDLE : S_GAP;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        S_GAP: begin
          if (gcnt == GCW'(GAP - 1)) state <= S_IDLE;
          else                       gcnt  <= gcnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// Scoreboard bench for cdc_xfer_arbiter: expected launches are queued when requests are
// driven and compared when chan_load appears; a GAP=0/TIMEOUT=1 instance covers back-to-back launches.
module tb_cdc_xfer_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic [7:0]  chan_data;
  logic        chan_load;
  logic        chan_ack = 1'b0;
  logic        busy;
  logic        timeout_err;

  logic [3:0]  req2 = '0;
  logic [31:0] req_data2 = {4{8'h5A}};
  logic [3:0]  gnt2;
  logic [1:0]  gnt_id2;
  logic [7:0]  chan_data2;
  logic        chan_load2;
  logic        chan_ack2 = 1'b0;
  logic        busy2;
  logic        timeout_err2;

  cdc_xfer_arbiter dut (
    .CLK(CLK), .RST(RST), .req(req), .req_data(req_data), .gnt(gnt), .gnt_id(gnt_id),
    .chan_data(chan_data), .chan_load(chan_load), .chan_ack(chan_ack), .busy(busy),
    .timeout_err(timeout_err)
  );

  cdc_xfer_arbiter #(.GAP(0), .TIMEOUT(1)) dut2 (
    .CLK(CLK), .RST(RST), .req(req2), .req_data(req_data2), .gnt(gnt2), .gnt_id(gnt_id2),
    .chan_data(chan_data2), .chan_load(chan_load2), .chan_ack(chan_ack2), .busy(busy2),
    .timeout_err(timeout_err2)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk = 0, n_pass = 0;
  int   cyc = 0, load_cyc = 0, to_cyc = 0, n_load = 0, to_cnt = 0;
  bit   prev_load = 1'b0, hold_en = 1'b0;
  logic [7:0] held_exp = '0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Main-instance monitor: scoreboard pop on launch, one-cycle pulses, chan_data hold.
  always @(negedge CLK) begin
    if (prev_load) begin
      check("load_pulse", chan_load, 0);
      check("gnt_pulse", gnt, 0);
    end
    if (chan_load === 1'b1) begin
      if (sb.size() == 0) check("unexp_load", 1, 0);
      else begin
        e = sb.pop_front();
        check("gnt", gnt, 32'd1 << e.id);
        check("gnt_id", gnt_id, e.id);
        check("chan_data", chan_data, e.data);
        held_exp = e.data;
      end
      load_cyc = cyc;
      n_load++;
    end else if (hold_en) check("data_hold", chan_data, held_exp);
    if (timeout_err === 1'b1) begin
      to_cnt++;
      to_cyc = cyc;
    end
    prev_load = (chan_load === 1'b1);
  end

  task automatic nedge();
    @(negedge CLK);
    #2;
  endtask

  task automatic push(int id, logic [7:0] d);
    exp_t x;
    x.id = 2'(id);
    x.data = d;
    sb.push_back(x);
  endtask

  task automatic wait_load(string tag);
    int n = 0;
    int start = n_load;
    while (n_load == start && n < 200) begin
      nedge();
      n++;
    end
    if (n_load == start) check({tag, "_no_load"}, 0, 1);
  endtask

  // Ack high during the cycle n after the launch cycle; returns just after the sampling edge.
  task automatic ack_after(int n);
    repeat (n) @(posedge CLK);
    #1 chan_ack = 1'b1;
    @(posedge CLK);
    #1 chan_ack = 1'b0;
  endtask

  task automatic busy_drop(string tag);
    nedge();
    nedge();
    check({tag, "_busy_hold"}, busy, 1);
    nedge();
    check({tag, "_busy_drop"}, busy, 0);
  endtask

  task automatic do_reset(int edges);
    hold_en = 1'b0;
    RST = 1'b1;
    repeat (edges) @(posedge CLK);
    #1 RST = 1'b0;
    sb.delete();
    held_exp = '0;
    nedge();
    check("rst_gnt", gnt, 0);
    check("rst_gnt_id", gnt_id, 0);
    check("rst_chan_data", chan_data, 0);
    check("rst_chan_load", chan_load, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout_err", timeout_err, 0);
    hold_en = 1'b1;
  endtask

  initial begin
    int l3, base, n, prev, nl;
    bit have, pl;

    // 1: single request
    nedge();
    do_reset(2);
    req_data = 32'h00A5_0000;
    req = 4'b0100;
    push(2, 8'hA5);
    wait_load("t1");
    req = '0;
    ack_after(5);
    busy_drop("t1");
    check("t1_gnt_id_held", gnt_id, 2);
    check("t1_data_held", chan_data, 8'hA5);

    // 2: fairness with all requesters asserted
    do_reset(1);
    base = to_cnt;
    req_data = 32'h4433_2211;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) push(i % 4, 8'(8'h11 * ((i % 4) + 1)));
    for (int i = 0; i < 5; i++) begin
      wait_load("t2");
      if (i == 4) req = '0;
      ack_after(3);
    end
    busy_drop("t2");
    check("t2_no_timeout", to_cnt, base);

    // 3: lost ack times out; pointer left at 2 wraps to lane 0
    req = 4'b0010;
    push(1, 8'h22);
    wait_load("t3");
    l3 = load_cyc;
    req = 4'b0011;
    push(0, 8'h11);
    base = to_cnt;
    n = 0;
    while (to_cnt == base && n < 100) begin
      nedge();
      n++;
    end
    check("t3_timeout_seen", to_cnt, base + 1);
    check("t3_timeout_lat", to_cyc - l3, 63);
    nedge();
    check("t3_busy_hold", busy, 1);
    nedge();
    check("t3_busy_drop", busy, 0);
    wait_load("t3b");
    req = '0;

    // 4: ack on the very cycle the timeout would fire
    base = to_cnt;
    ack_after(62);
    busy_drop("t4");
    check("t4_no_timeout", to_cnt, base);

    // 5: stray acks in IDLE and GAP, then reset mid-transfer
    #1 chan_ack = 1'b1;
    @(posedge CLK);
    #1 chan_ack = 1'b0;
    nedge();
    check("t5_idle_ack_busy", busy, 0);
    check("t5_idle_ack_load", chan_load, 0);
    req = 4'b0001;
    push(0, 8'h11);
    wait_load("t5a");
    req = '0;
    ack_after(2);
    chan_ack = 1'b1;
    @(posedge CLK);
    #1 chan_ack = 1'b0;
    nedge();
    check("t5_gap_ack_busy_hold", busy, 1);
    nedge();
    check("t5_gap_ack_busy_drop", busy, 0);
    check("t5_no_timeout", to_cnt, base);

    req = 4'b0100;
    push(2, 8'h33);
    wait_load("t5b");
    req = '0;
    repeat (3) nedge();
    do_reset(1);
    repeat (70) nedge();
    check("t5_abandon_no_timeout", to_cnt, base);
    check("t5_abandon_idle", busy, 0);
    req = 4'b1000;
    push(3, 8'h44);
    wait_load("t5c");
    req = '0;
    ack_after(1);
    busy_drop("t5c");

    // 6: GAP=0, TIMEOUT=1 instance
    req2 = 4'b0001;
    chan_ack2 = 1'b1;
    have = 0; prev = 0; nl = 0;
    for (int i = 0; i < 14; i++) begin
      nedge();
      if (chan_load2) begin
        check("t6_gnt_id", gnt_id2, 0);
        if (have) check("t6_ack_spacing", cyc - prev, 2);
        have = 1; prev = cyc; nl++;
      end
    end
    check("t6_ack_nload", nl >= 6, 1);
    chan_ack2 = 1'b0;
    pl = chan_load2;
    nl = 0;
    for (int i = 0; i < 14; i++) begin
      nedge();
      check("t6_err_after_load", timeout_err2, pl);
      if (chan_load2) nl++;
      pl = chan_load2;
    end
    check("t6_noack_nload", nl >= 6, 1);
    req2 = '0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
